ppct_serial_mult: RTL and testbench

Iterative approximate multiplier controller for the PPCT family. It accepts one operand pair per transaction and sequences the partial-product rows over WIDTH cycles, one row per cycle, into a shared accumulator. It applies column truncation with a run-time THETA, so one small datapath covers every `column_approx_<THETA>_<WIDTH>` variant. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/ppct_serial_mult_if.sv | 26 ++
 rtl/ppct_serial_mult.sv | 102 ++++++++++
 tb/tb_ppct_serial_mult.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ppct_serial_mult_if.sv
// Handshake bundle for ppct_serial_mult: operand side (in_valid/in_ready,
// x, y, theta), result side (out_valid/out_ready, z) and busy status.
interface ppct_serial_mult_if #(
  parameter int WIDTH = 8,
  parameter int TW    = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [TW-1:0]      theta;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;
  logic               busy;

  modport master (
    output in_valid, x, y, theta, out_ready,
    input  in_ready, out_valid, z, busy
  );

  modport slave (
    input  in_valid, x, y, theta, out_ready,
    output in_ready, out_valid, z, busy
  );
endinterface

// File: rtl/ppct_serial_mult.sv
// Iterative column-truncated multiplier: one partial-product row per cycle.
// Ports: clk, rst (async, active-high), bus (ppct_serial_mult_if.slave).
module ppct_serial_mult #(
  parameter int WIDTH = 8,
  parameter int TW    = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst,
  ppct_serial_mult_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [TW-1:0] LAST = TW'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   xr;
  logic [WIDTH-1:0]   yr;
  logic [TW-1:0]      thr;
  logic [TW-1:0]      r;
  logic [2*WIDTH-1:0] acc;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [TW:0]        k;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] row;

  // Row r drops its lowest (theta-r) bits so every column below
  // theta is left out of the sum.
  always_comb begin
    k   = {1'b0, thr} - {1'b0, r};
    m   = xr;
    if (r < thr) begin
      m = (xr >> k) << k;
    end
    row = {{WIDTH{1'b0}}, m & {WIDTH{yr[r]}}} << r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      xr          <= '0;
      yr          <= '0;
      thr         <= '0;
      r           <= '0;
      acc         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr         <= bus.x;
            yr         <= bus.y;
            thr        <= bus.theta;
            acc        <= '0;
            r          <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc + row;
          r   <= r + 1'b1;
          if (r == LAST) begin
            r           <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.z         = acc;

endmodule

// File: tb/tb_ppct_serial_mult.sv
// Directed and swept checks for ppct_serial_mult (WIDTH=8).
// Expected values are hand-computed or from a column-truncation model.
module tb_ppct_serial_mult;

  localparam int W  = 8;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_acc = -1;

  ppct_serial_mult_if #(.WIDTH(W), .TW(TW)) bus ();

  ppct_serial_mult #(.WIDTH(W), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Column-truncated product: keep bit products in columns >= th.
  function automatic logic [15:0] golden(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input int th);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[j] && b[i] && (i + j) >= th)
          s += 32'(1) << (i + j);
    return s[15:0];
  endfunction

  task automatic wait_ready(input string tag, output bit ok);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    if (!ok) chk({tag, "_rdy_to"}, bus.in_ready, 1);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Full transaction with out_ready high; checks latency, z, turnaround.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] th, input logic [15:0] exp,
                         input string tag);
    bit ok;
    int n;
    wait_ready(tag, ok);
    if (!ok) return;
    bus.in_valid = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.theta = th;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (last_acc >= 0) chk({tag, "_gap"}, 32'(cyc - last_acc >= 10), 1);
    last_acc = cyc;
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_inrdy_run"}, bus.in_ready, 0);
    wait_valid(tag, n);
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_z"}, bus.z, exp);
    @(negedge clk);
    chk({tag, "_ov_drop"}, bus.out_valid, 0);
    chk({tag, "_inrdy_back"}, bus.in_ready, 1);
  endtask

  initial begin
    bit ok;
    int n;
    logic [7:0] a, b;
    logic [2:0] th;

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.theta     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_inrdy", bus.in_ready, 1);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_z", bus.z, 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(8'd255, 8'd255, 3'd0, 16'd65025, "exact_ff");
    run_txn(8'd255, 8'd255, 3'd3, 16'd65008, "trunc_ff");
    run_txn(8'd13, 8'd6, 3'd3, 16'd72, "trunc_13x6");
    run_txn(8'd7, 8'd1, 3'd3, 16'd0, "mask_row0");

    // Backpressure with operand changes during RUN and DONE.
    bus.out_ready = 1'b0;
    wait_ready("bp", ok);
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.x = 8'd200;
      bus.y = 8'd100;
      bus.theta = 3'd0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.x = 8'd255;
      bus.y = 8'd255;
      bus.theta = 3'd7;
      wait_valid("bp", n);
      chk("bp_lat", n, 9);
      chk("bp_z", bus.z, 20000);
      for (int i = 0; i < 5; i++) begin
        bus.in_valid = 1'b1;
        bus.x = 8'(i + 1);
        @(negedge clk);
        chk("bp_ov_hold", bus.out_valid, 1);
        chk("bp_z_hold", bus.z, 20000);
        chk("bp_inrdy", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_ov_drop", bus.out_valid, 0);
      chk("bp_inrdy_back", bus.in_ready, 1);
    end

    // Reset at r=4 discards the in-flight product.
    wait_ready("mid_rst", ok);
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.x = 8'd255;
      bus.y = 8'd255;
      bus.theta = 3'd0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy_pre", bus.busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_busy", bus.busy, 0);
      chk("mid_inrdy", bus.in_ready, 1);
      chk("mid_z", bus.z, 0);
      chk("mid_ov", bus.out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
    last_acc = -1;
    run_txn(8'd3, 8'd5, 3'd0, 16'd15, "post_rst");

    // Sweep with back-to-back accepts.
    for (int t = 0; t < 1000; t++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      th = 3'($urandom_range(0, 7));
      run_txn(a, b, th, golden(a, b, int'(th)), "sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
